cnn_layer_driver: RTL and testbench
===================================

# cnn_layer_driver

Sequencer that sits on the initiator side of the `cnn_layer` load/valid interface. It collects an input feature map as an element stream and presents it as the parallel layer input. It then issues one `load` per layer, waits for `valid`, and captures the layer output back into the same buffer, chaining `NUM_LAYERS` layers. It finally streams the result out element by element. Input and output maps are both 384 elements of `data_len` bits, so one buffer serves every layer.

## Interface
- `NUM_ELEM`, 384, elements per map (32*3*4 input = 32*12 output).
- `NUM_LAYERS`, 4, layers run per job (1..15).
- `FIRST_LAYER`, 4'd1, `layer_cs` code of the first layer; layer k uses `FIRST_LAYER + k`.
- `TIMEOUT`, 4096, maximum WAIT cycles per layer before error.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin a job; sampled only in IDLE or ERR.
- `in_valid`  in  1  input element valid.
- `in_data`  in  `data_len`  input element.
- `in_ready`  out  1  driver accepts input element.
- `layer_load`  out  1  one-cycle run pulse to layer.
- `layer_cs`  out  4  layer select code.
- `layer_d`  out  NUM_ELEM*`data_len`  buffer contents; element i at bits [i*`data_len` +: `data_len`].
- `layer_valid`  in  1  layer finished (level).
- `layer_q`  in  NUM_ELEM*`data_len`  layer result, same packing.
- `out_valid`  out  1  output element valid.
- `out_data`  out  `data_len`  output element.
- `out_last`  out  1  marks element NUM_ELEM-1.
- `out_ready`  in  1  downstream accepts element.
- `busy`  out  1  state is not IDLE and not ERR.
- `done`  out  1  one-cycle pulse after the last output transfer.
- `err`  out  1  timeout flag, sticky.

## Operation
- States: IDLE, FILL, LOAD, WAIT, DRAIN, ERR.
- IDLE: if `start` is high, go to FILL with `idx`=0 and `layer_idx`=0.
- FILL: `in_ready`=1. On each `in_valid & in_ready`, write buffer[idx] and increment `idx`. The transfer at idx=NUM_ELEM-1 moves to LOAD.
- LOAD: exactly one cycle. `layer_load`=1 and `layer_cs`=FIRST_LAYER+layer_idx. Clear the timer. Go to WAIT.
- WAIT: `layer_cs` and `layer_d` are held stable. The timer increments every cycle.
  - `layer_valid` is ignored in the first WAIT cycle, so a stale FINI level from the previous layer is masked.
  - From the second WAIT cycle on, `layer_valid`=1 writes the whole buffer from `layer_q`.
  - After the capture: if layer_idx=NUM_LAYERS-1, go to DRAIN with idx=0. Otherwise increment `layer_idx` and go to LOAD.
  - If the timer reaches TIMEOUT with no valid, go to ERR and set `err`.
- DRAIN: `out_valid`=1, `out_data`=buffer[idx], `out_last`=(idx==NUM_ELEM-1).
  - On `out_ready`, increment `idx`.
  - The last transfer goes to IDLE and pulses `done` in the following cycle.
  - `out_data` is held while `out_ready`=0.
- ERR: all handshake outputs are 0 and `err`=1. `start` clears `err` and enters FILL with both counters at 0.
- The buffer is written only in FILL and on a WAIT capture. `layer_d` is the buffer, unconditionally.
- The layer code is `FIRST_LAYER + layer_idx`, truncated to 4 bits.
- `start` while busy is ignored.

## Timing
- Reset (asynchronous, immediate): state=IDLE, buffer=0, idx=0, layer_idx=0, timer=0.
  - Outputs at reset: `layer_load`=0, `layer_cs`=0, `in_ready`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, `err`=0.
- Reset mid-job aborts with no further `layer_load`.
- `start` at edge T: `in_ready`=1 from T+1.
- Final input accepted at edge T: `layer_load`=1 during cycle T+1 (registered output).
- Capture at edge T:
  - next layer `layer_load`=1 during T+1, or
  - `out_valid`=1 during T+1 for the last layer.
- Minimum per-layer overhead: 1 LOAD cycle plus 2 WAIT cycles.
- Fill takes NUM_ELEM accepted beats; drain takes NUM_ELEM accepted beats. Back-to-back transfers run one per cycle.
- `layer_cs` is 0 in IDLE, FILL and DRAIN. It is valid from the LOAD cycle until the capture edge.

## Test plan
- Fill elements 0..383 with in_data=i, NUM_LAYERS=1, layer model returns q=d+1 after 10 cycles. Required response:
  - exactly one `layer_load` with `layer_cs`=1;
  - output stream 1..384 with `out_last` only on the 384th element;
  - `done` pulses once.
- NUM_LAYERS=4, layer model adds `layer_cs` to each element. Required response:
  - `layer_cs` sequence 1,2,3,4;
  - output element i = i+10;
  - four `layer_load` pulses, each one cycle.
- Stale valid: model holds `layer_valid`=1 from the previous layer through the next LOAD and first WAIT cycle, then drops it for 5 cycles. Required response: no capture until the new valid rises.
- Random `in_valid` and `out_ready` throttling at 30% duty. Required response:
  - output is identical to the unthrottled run;
  - `out_data` is stable while stalled;
  - `in_ready`=0 outside FILL.
- Layer model never asserts valid, TIMEOUT=64. Required response:
  - ERR with `err`=1 after 64 WAIT cycles;
  - `start` clears `err` and restarts FILL.
- Assert `rst` mid-WAIT and mid-DRAIN. Required response: all outputs are at reset values in the same cycle; a new job then completes correctly.

Source files
------------

// File: rtl/cnn_layer_driver.sv
// cnn_layer_driver: fills a feature-map buffer, chains NUM_LAYERS
// cnn_layer load/valid runs over it, then streams the result out.
module cnn_layer_driver #(
    parameter int          DATA_LEN    = 16,
    parameter int          NUM_ELEM    = 384,
    parameter int          NUM_LAYERS  = 4,
    parameter logic [3:0]  FIRST_LAYER = 4'd1,
    parameter int          TIMEOUT     = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [DATA_LEN-1:0]          in_data,
    output logic                         in_ready,
    output logic                         layer_load,
    output logic [3:0]                   layer_cs,
    output logic [NUM_ELEM*DATA_LEN-1:0] layer_d,
    input  logic                         layer_valid,
    input  logic [NUM_ELEM*DATA_LEN-1:0] layer_q,
    output logic                         out_valid,
    output logic [DATA_LEN-1:0]          out_data,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int IW = $clog2(NUM_ELEM);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ELEM - 1);
    localparam logic [3:0]    LAST_LAYER = 4'(NUM_LAYERS - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, FILL, LOAD, WAIT, DRAIN, ERR
    } state_t;

    state_t              state;
    logic [DATA_LEN-1:0] buffer [NUM_ELEM];
    logic [IW-1:0]       idx;
    logic [3:0]          layer_idx;
    logic [TW-1:0]       timer;

    for (genvar i = 0; i < NUM_ELEM; i++) begin : g_pack
        assign layer_d[i*DATA_LEN +: DATA_LEN] = buffer[i];
    end

    assign in_ready  = (state == FILL);
    assign out_valid = (state == DRAIN);
    assign out_data  = buffer[idx];
    assign out_last  = (state == DRAIN) && (idx == LAST_IDX);
    assign busy      = (state != IDLE) && (state != ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            layer_idx  <= '0;
            timer      <= '0;
            layer_load <= 1'b0;
            layer_cs   <= 4'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < NUM_ELEM; i++) buffer[i] <= '0;
        end else begin
            layer_load <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                IDLE, ERR: begin
                    if (start) begin
                        state     <= FILL;
                        idx       <= '0;
                        layer_idx <= '0;
                        err       <= 1'b0;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        buffer[idx] <= in_data;
                        if (idx == LAST_IDX) begin
                            idx        <= '0;
                            state      <= LOAD;
                            layer_load <= 1'b1;
                            layer_cs   <= FIRST_LAYER + layer_idx;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                LOAD: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // timer==0 marks the first WAIT cycle: stale valid is masked
                    if (layer_valid && timer != '0) begin
                        for (int i = 0; i < NUM_ELEM; i++)
                            buffer[i] <= layer_q[i*DATA_LEN +: DATA_LEN];
                        if (layer_idx == LAST_LAYER) begin
                            state    <= DRAIN;
                            idx      <= '0;
                            layer_cs <= 4'd0;
                        end else begin
                            layer_idx  <= layer_idx + 4'd1;
                            state      <= LOAD;
                            layer_load <= 1'b1;
                            layer_cs   <= FIRST_LAYER + layer_idx + 4'd1;
                        end
                    end else if (timer == LAST_TICK) begin
                        state    <= ERR;
                        err      <= 1'b1;
                        layer_cs <= 4'd0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_driver.sv
// tb_cnn_layer_driver: randomized jobs against a behavioural layer
// model and an arithmetic reference of the chained layer result.
module tb_cnn_layer_driver;

    localparam int         DL = 16;
    localparam int         NE = 384;
    localparam int         NL = 4;
    localparam int         TO = 64;
    localparam logic [3:0] FL = 4'd1;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready;
    logic [DL-1:0] in_data, out_data;
    logic          layer_load, layer_valid = 1'b0;
    logic [3:0]    layer_cs;
    logic [NE*DL-1:0] layer_d, layer_q = '0;
    logic          out_valid, out_last, out_ready;
    logic          busy, done, err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cnn_layer_driver #(
        .DATA_LEN(DL), .NUM_ELEM(NE), .NUM_LAYERS(NL),
        .FIRST_LAYER(FL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .layer_load(layer_load), .layer_cs(layer_cs), .layer_d(layer_d),
        .layer_valid(layer_valid), .layer_q(layer_q),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Layer model: 0 adds cs, 1 adds one, 2 adds cs with a stale
    // valid level across LOAD and the first WAIT cycle, 3 never answers.
    int mmode = 0;
    int lat = 10;
    int k = 0;
    bit active = 0;
    logic [NE*DL-1:0] good_q;

    always @(negedge clk) begin
        if (rst) begin
            active = 0;
            layer_valid = 1'b0;
            layer_q = '0;
        end else begin
            if (layer_load) begin
                active = 1;
                k = 0;
                for (int i = 0; i < NE; i++)
                    good_q[i*DL +: DL] = layer_d[i*DL +: DL]
                        + ((mmode == 1) ? DL'(1) : DL'(layer_cs));
            end else if (active) begin
                k++;
            end
            if (active) begin
                case (mmode)
                    0, 1: begin
                        layer_valid = (k >= lat);
                        layer_q = good_q;
                    end
                    2: begin
                        layer_valid = (k <= 1) || (k >= 7);
                        layer_q = (k >= 7) ? good_q : {NE{16'hdead}};
                    end
                    default: layer_valid = 1'b0;
                endcase
            end
        end
    end

    // Protocol monitor, sampled mid-cycle
    logic [3:0] cs_q[$];
    logic prev_load = 1'b0;
    logic prev_stall = 1'b0;
    logic [DL-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (layer_load) begin
                cs_q.push_back(layer_cs);
                chk("load_one_cycle", int'(prev_load), 0);
            end
            if (in_ready)
                chk("in_ready_excl", int'(out_valid | layer_load | err), 0);
            if (in_ready | out_valid)
                chk("cs_zero", int'(layer_cs), 0);
            if (prev_stall && out_valid)
                chk("stall_hold", int'(out_data), int'(prev_data));
        end
        prev_load  = layer_load & ~rst;
        prev_stall = out_valid & ~out_ready & ~rst;
        prev_data  = out_data;
    end

    logic [DL-1:0] src [NE];
    logic [DL-1:0] exp_o [NE];

    task automatic reset_check(input string tag);
        int loads;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk({tag, "_load"}, int'(layer_load), 0);
        chk({tag, "_cs"}, int'(layer_cs), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_buf_zero"}, int'(layer_d == '0), 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        loads = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (layer_load) loads++;
        end
        chk({tag, "_no_load"}, loads, 0);
    endtask

    // dmode: 0 index data, 1 fresh random, 2 keep previous
    // abort: 0 none, 1 reset in WAIT, 2 reset in DRAIN, 3 expect timeout
    task automatic run_job(input string tag, input int dmode,
                           input int in_pct, input int out_pct,
                           input int abort);
        int cnt, cyc;
        bit acc;
        for (int i = 0; i < NE; i++) begin
            if (dmode == 0) src[i] = DL'(i);
            else if (dmode == 1) src[i] = DL'($urandom);
        end
        for (int i = 0; i < NE; i++) begin
            exp_o[i] = src[i];
            for (int l = 0; l < NL; l++)
                exp_o[i] = exp_o[i] + ((mmode == 1) ? DL'(1) : DL'(FL + l));
        end
        cs_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_ready_after_start"}, int'(in_ready), 1);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_err_clear"}, int'(err), 0);

        cnt = 0;
        cyc = 0;
        while (cnt < NE && cyc < 20000) begin
            in_valid = ($urandom_range(99) < in_pct);
            in_data = src[cnt];
            acc = in_valid & in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) cnt++;
        end
        in_valid = 1'b0;
        chk({tag, "_fill_count"}, cnt, NE);
        chk({tag, "_first_load"}, int'(layer_load), 1);
        chk({tag, "_first_cs"}, int'(layer_cs), int'(FL));
        chk({tag, "_ready_off"}, int'(in_ready), 0);

        if (abort == 1) begin
            repeat (3) @(posedge clk);
            #1;
            reset_check({tag, "_rst_wait"});
            return;
        end
        if (abort == 3) begin
            cyc = 0;
            while (!err && cyc < 200) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk({tag, "_timeout_cycles"}, cyc, TO + 1);
            chk({tag, "_err_busy"}, int'(busy), 0);
            chk({tag, "_err_ready"}, int'(in_ready), 0);
            chk({tag, "_err_ovalid"}, int'(out_valid), 0);
            chk({tag, "_err_cs"}, int'(layer_cs), 0);
            repeat (5) @(posedge clk);
            #1;
            chk({tag, "_err_sticky"}, int'(err), 1);
            return;
        end

        // start pulses while busy must be ignored
        cyc = 0;
        while (!out_valid && cyc < 2000) begin
            start = ($urandom_range(1) == 1);
            @(posedge clk); #1;
            cyc++;
            if (in_ready) chk({tag, "_ready_in_layers"}, int'(in_ready), 0);
        end
        start = 1'b0;
        chk({tag, "_reach_drain"}, int'(out_valid), 1);

        cnt = 0;
        cyc = 0;
        while (cnt < NE && cyc < 20000) begin
            if (abort == 2 && cnt == NE / 2) begin
                reset_check({tag, "_rst_drain"});
                return;
            end
            out_ready = ($urandom_range(99) < out_pct);
            if (out_valid && out_ready) begin
                if (out_data !== exp_o[cnt] || cnt == 0 || cnt == NE - 1)
                    chk({tag, "_data"}, int'(out_data), int'(exp_o[cnt]));
                else
                    n_cmp++;
                chk({tag, "_last"}, int'(out_last), int'(cnt == NE - 1));
                cnt++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk({tag, "_drain_count"}, cnt, NE);
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_idle"}, int'(busy), 0);
        chk({tag, "_ovalid_off"}, int'(out_valid), 0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, int'(done), 0);
        chk({tag, "_load_count"}, cs_q.size(), NL);
        for (int l = 0; l < NL; l++)
            if (l < cs_q.size())
                chk({tag, "_cs_seq"}, int'(cs_q[l]), int'(FL) + l);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        reset_check("reset");

        mmode = 1;
        run_job("add_one", 0, 100, 100, 0);
        mmode = 0;
        run_job("add_cs", 2, 100, 100, 0);
        mmode = 2;
        run_job("stale", 2, 100, 100, 0);
        mmode = 0;
        run_job("throttle", 2, 30, 30, 0);
        run_job("rand", 1, 30, 30, 0);
        lat = 1;
        run_job("fast_layer", 1, 100, 60, 0);
        lat = 10;

        mmode = 3;
        run_job("timeout", 1, 100, 100, 3);
        mmode = 0;
        run_job("after_err", 1, 70, 70, 0);

        run_job("abort_wait", 1, 100, 100, 1);
        run_job("after_rst_wait", 1, 100, 100, 0);
        run_job("abort_drain", 1, 100, 50, 2);
        run_job("after_rst_drain", 1, 100, 100, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
